// File: rtl/mips_imem_arb.sv
// Two-port (fetch I / data D) arbiter onto a single-ported instruction/data memory.
// D has priority; a saturating counter lets I through after STARVE_LIM consecutive D wins.
`ifndef MIPS_ADDR_WIDTH
`define MIPS_ADDR_WIDTH 32
`endif
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

module mips_imem_arb #(
  parameter int STARVE_LIM = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          I_read,
  input  logic                          I_write,
  input  logic [`MIPS_ADDR_WIDTH-3:0]   I_addr,
  input  logic [`MIPS_DATA_WIDTH-1:0]   I_wdata,
  output logic [`MIPS_DATA_WIDTH-1:0]   I_rdata,
  output logic                          I_stall,
  input  logic                          D_read,
  input  logic                          D_write,
  input  logic [`MIPS_ADDR_WIDTH-3:0]   D_addr,
  input  logic [`MIPS_DATA_WIDTH-1:0]   D_wdata,
  output logic [`MIPS_DATA_WIDTH-1:0]   D_rdata,
  output logic                          D_stall,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [`MIPS_ADDR_WIDTH-3:0]   mem_addr,
  output logic [`MIPS_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [`MIPS_DATA_WIDTH-1:0]   mem_rdata,
  input  logic                          mem_ready
);

  localparam int AW = `MIPS_ADDR_WIDTH - 2;
  localparam int DW = `MIPS_DATA_WIDTH;
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          state_reg, state_next;
  logic            mem_we_reg;
  logic [AW-1:0]   mem_addr_reg;
  logic [DW-1:0]   mem_wdata_reg;
  logic [2:0]      starve_cnt_reg;
  logic [1:0]      done_reg;
  logic [DW-1:0]   rdata_reg [2];

  // Index 0 is the fetch port, index 1 the data port.
  logic [1:0]      port_rd, port_wr, port_req, port_elig, port_busy, finish, grant;
  logic [AW-1:0]   port_addr  [2];
  logic [DW-1:0]   port_wdata [2];
  logic            starve_hit, launch, sel;

  assign port_rd[0]    = I_read;
  assign port_wr[0]    = I_write;
  assign port_addr[0]  = I_addr;
  assign port_wdata[0] = I_wdata;
  assign port_rd[1]    = D_read;
  assign port_wr[1]    = D_write;
  assign port_addr[1]  = D_addr;
  assign port_wdata[1] = D_wdata;
  assign port_busy[0]  = (state_reg == BUSY_I);
  assign port_busy[1]  = (state_reg == BUSY_D);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign port_req[gi]  = port_rd[gi] | port_wr[gi];
      // A port whose access just completed sits out one IDLE cycle so it is not relaunched.
      assign port_elig[gi] = port_req[gi] & ~done_reg[gi];
      assign finish[gi]    = port_busy[gi] & mem_ready;
    end
  endgenerate

  assign starve_hit = (starve_cnt_reg == STARVE_MAX);
  assign grant[0]   = (state_reg == IDLE) & port_elig[0] & (~port_elig[1] | starve_hit);
  assign grant[1]   = (state_reg == IDLE) & port_elig[1] & ~grant[0];
  assign launch     = |grant;
  assign sel        = grant[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant[1])      state_next = BUSY_D;
        else if (grant[0]) state_next = BUSY_I;
      end
      BUSY_I:  if (mem_ready) state_next = IDLE;
      BUSY_D:  if (mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        // Write wins when a port raises both read and write.
        mem_we_reg    <= port_wr[sel];
        mem_addr_reg  <= port_addr[sel];
        mem_wdata_reg <= port_wdata[sel];
      end
      if (grant[0]) begin
        starve_cnt_reg <= '0;
      end else if (grant[1]) begin
        if (!port_elig[0])             starve_cnt_reg <= '0;
        else if (!starve_hit)          starve_cnt_reg <= starve_cnt_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg     <= '0;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
    end else begin
      done_reg <= finish;
      for (int i = 0; i < 2; i++) begin
        if (finish[i] && !mem_we_reg) rdata_reg[i] <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state_reg != IDLE);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign I_rdata   = rdata_reg[0];
  assign D_rdata   = rdata_reg[1];
  assign I_stall   = port_req[0] & ~done_reg[0];
  assign D_stall   = port_req[1] & ~done_reg[1];

endmodule

// File: tb/tb_mips_imem_arb.sv
// Directed bench for mips_imem_arb: single fetch, collision, starvation guard,
// slow write and reset during an access.
module tb_mips_imem_arb;

  logic        clk, rst_n;
  logic        I_read, I_write, D_read, D_write;
  logic [29:0] I_addr, D_addr, mem_addr;
  logic [31:0] I_wdata, D_wdata, I_rdata, D_rdata, mem_wdata, mem_rdata;
  logic        I_stall, D_stall, mem_req, mem_we, mem_ready;
  logic        use_fix;
  logic [31:0] fix_val;

  int total = 0;
  int bad   = 0;

  mips_imem_arb #(.STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_read(I_read), .I_write(I_write), .I_addr(I_addr), .I_wdata(I_wdata),
    .I_rdata(I_rdata), .I_stall(I_stall),
    .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_rdata(D_rdata), .D_stall(D_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Memory model: each word reads back as its byte address plus 0x10000000.
  assign mem_rdata = use_fix ? fix_val : ({mem_addr, 2'b00} + 32'h1000_0000);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  initial begin
    int          stall_n, req_n, d_low, i_low, d_cnt, low_n;
    bit          seen, d_drop, i_drop, i_served, d_adv;
    logic [29:0] g1, g3, g;
    logic [29:0] log_q[$];
    logic [29:0] exp_order [7];

    clk = 0; rst_n = 0;
    I_read = 1; I_write = 0; I_addr = '0; I_wdata = '0;
    D_read = 0; D_write = 0; D_addr = '0; D_wdata = '0;
    mem_ready = 0; use_fix = 0; fix_val = '0;

    // Reset state, with stall following the raw request
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
    check("rst_rdata", {I_rdata, D_rdata}, 0);
    check("rst_I_stall_eq_req", I_stall, 1);
    I_read = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // Single fetch at 0x10, memory ready immediately
    use_fix = 1; fix_val = 32'h2402_000A; mem_ready = 1;
    I_addr = 30'h10; I_read = 1;
    stall_n = 0; req_n = 0; seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (seen) I_read = 0;
      #1;
      if (I_stall) stall_n++;
      if (mem_req) req_n++;
      if (I_read && !I_stall) seen = 1;
      @(negedge clk);
    end
    check("fetch_stall_cycles", stall_n, 2);
    check("fetch_single_req", req_n, 1);
    check("fetch_rdata", I_rdata, 32'h2402_000A);
    use_fix = 0;

    // Simultaneous I and D reads: D first, I two cycles later
    D_addr = 30'h20; I_addr = 30'h44; D_read = 1; I_read = 1;
    d_low = -1; i_low = -1; d_drop = 0; i_drop = 0; g1 = '0; g3 = '0;
    for (int n = 0; n < 10; n++) begin
      if (d_drop) D_read = 0;
      if (i_drop) I_read = 0;
      #1;
      if (n == 1 && mem_req) g1 = mem_addr;
      if (n == 3 && mem_req) g3 = mem_addr;
      if (D_read && !D_stall) begin d_low = n; d_drop = 1; end
      if (I_read && !I_stall) begin i_low = n; i_drop = 1; end
      @(negedge clk);
    end
    check("both_first_grant", g1, 30'h20);
    check("both_second_grant", g3, 30'h44);
    check("both_D_done_cycle", d_low, 2);
    check("both_I_done_cycle", i_low, 4);
    check("both_D_rdata", D_rdata, 32'h1000_0080);
    check("both_I_rdata", I_rdata, 32'h1000_0110);

    // Starvation guard: I waits while D issues six reads
    D_addr = 30'h200; D_read = 1; I_addr = 30'h100; I_read = 1;
    d_cnt = 0; i_served = 0; d_adv = 0;
    for (int n = 0; n < 60 && d_cnt < 6; n++) begin
      if (d_adv) begin d_adv = 0; D_addr = D_addr + 30'd1; end
      I_read = !i_served;
      #1;
      if (mem_req) begin
        log_q.push_back(mem_addr);
        if (log_q.size() == 4) check("starve_at_limit", dut.starve_cnt_reg, 4);
        if (mem_addr == 30'h100) check("starve_cleared", dut.starve_cnt_reg, 0);
      end
      if (I_read && !I_stall) i_served = 1;
      // The fetch requester stands aside in the cycle a D completion is visible.
      if (D_read && !D_stall) begin d_cnt++; d_adv = 1; I_read = 0; end
      @(negedge clk);
    end
    D_read = 0; I_read = 0;
    exp_order = '{30'h200, 30'h201, 30'h202, 30'h203, 30'h100, 30'h204, 30'h205};
    check("starve_grant_count", log_q.size(), 7);
    for (int k = 0; k < 7; k++) begin
      g = (log_q.size() > k) ? log_q[k] : 30'h3FFF_FFFF;
      check($sformatf("starve_grant_%0d", k), g, exp_order[k]);
    end

    // Slow D write: bus held stable, read data untouched
    mem_ready = 0; D_addr = 30'h20; D_wdata = 32'hDEAD_BEEF; D_write = 1;
    low_n = -1; d_drop = 0;
    for (int n = 0; n < 12; n++) begin
      mem_ready = (n == 6);
      if (d_drop) D_write = 0;
      #1;
      if (n >= 1 && n <= 5)
        check($sformatf("wr_hold_%0d", n), {mem_req, mem_we, mem_addr, mem_wdata},
              {1'b1, 1'b1, 30'h20, 32'hDEAD_BEEF});
      if (n == 6) check("wr_stall_at_ready", D_stall, 1);
      if (D_write && !D_stall) begin low_n = n; d_drop = 1; end
      @(negedge clk);
    end
    check("wr_done_cycle", low_n, 7);
    check("wr_D_rdata_held", D_rdata, 32'h1000_0814);

    // Reset in the middle of a D read, then regrant
    mem_ready = 0; D_addr = 30'h30; D_read = 1;
    @(negedge clk);
    #1 check("rstmid_busy", mem_req, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("rstmid_mem_req", mem_req, 0);
    check("rstmid_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
    check("rstmid_rdata", {I_rdata, D_rdata}, 0);
    check("rstmid_D_stall", D_stall, 1);
    @(negedge clk);
    rst_n = 1; mem_ready = 1;
    low_n = -1; g = '0; d_drop = 0;
    for (int n = 0; n < 8; n++) begin
      if (d_drop) D_read = 0;
      #1;
      if (n == 1 && mem_req) g = mem_addr;
      if (D_read && !D_stall) begin low_n = n; d_drop = 1; end
      @(negedge clk);
    end
    check("rstmid_regrant_addr", g, 30'h30);
    check("rstmid_done_cycle", low_n, 2);
    check("rstmid_D_rdata", D_rdata, 32'h1000_00C0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
